cmsdk_mcu_gpio_in_cond: RTL and testbench

Input conditioning stage that sits directly downstream of the MCU pin multiplexer. It consumes the raw port input bus (p0_in/p1_in) and synchronises each bit. It optionally debounces each bit, then produces clean pin data plus per-bit sticky edge/level interrupt status. One instance per 16-bit port; outputs feed the GPIO register block and the NVIC interrupt inputs.

---
 rtl/cmsdk_mcu_gpio_pkg.sv | 38 +++
 rtl/cmsdk_mcu_gpio_in_cond_bit.sv | 96 +++++++++
 rtl/cmsdk_mcu_gpio_in_cond.sv | 86 ++++++++
 tb/tb_cmsdk_mcu_gpio_in_cond.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_mcu_gpio_pkg.sv
// -----------------------------------------------------------------------------
// cmsdk_mcu_gpio_pkg
// Shared constants and helpers for the MCU GPIO input conditioning path.
//   - Default port width, synchroniser depth and debounce counter width.
//   - Encodings of the per-bit interrupt type and polarity controls.
//   - gpio_int_set(): per-bit interrupt set condition.
// -----------------------------------------------------------------------------
package cmsdk_mcu_gpio_pkg;

  localparam int GPIO_WIDTH_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CNT_W_DEF    = 4;

  localparam logic INTTYPE_EDGE  = 1'b1;
  localparam logic INTTYPE_LEVEL = 1'b0;
  localparam logic INTPOL_HIGH   = 1'b1;
  localparam logic INTPOL_LOW    = 1'b0;

  // Edge types look at the rise/fall of the conditioned value; level types
  // compare the conditioned value to the polarity every cycle.
  function automatic logic gpio_int_set(
    input logic inten,
    input logic inttype,
    input logic intpol,
    input logic stable,
    input logic rise,
    input logic fall
  );
    logic hit;
    if (inttype == INTTYPE_EDGE) begin
      hit = (intpol == INTPOL_HIGH) ? rise : fall;
    end else begin
      hit = (stable == intpol);
    end
    return inten & hit;
  endfunction

endpackage

// File: rtl/cmsdk_mcu_gpio_in_cond_bit.sv
// -----------------------------------------------------------------------------
// cmsdk_mcu_gpio_in_cond_bit
// One port bit: SYNC_STAGES-deep synchroniser, optional debounce counter and
// the stable (conditioned) register.
//   HCLK       block clock
//   HRESET     synchronous active-high reset
//   pin_i      asynchronous raw pad value
//   db_en_i    debounce enable for this bit
//   db_limit_i debounce limit (cycles of disagreement tolerated)
//   stable_o   conditioned pin value (registered)
// Build option: CMSDK_MCU_GPIO_IN_COND_DEBOUNCE_EN adds the debounce counter;
// without it db_en_i/db_limit_i are ignored and stable follows syn.
// -----------------------------------------------------------------------------
module cmsdk_mcu_gpio_in_cond_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 4
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                pin_i,
  input  logic                db_en_i,
  input  logic [DB_CNT_W-1:0] db_limit_i,
  output logic                stable_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic                   stable_q, stable_d;

  // NOTE: the synchroniser flops get a reset like any other state; they are a
  // handful of flops, not a memory array, so clearing them costs nothing and
  // keeps the post-reset rising-edge timing deterministic.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign syn = sync_q[SYNC_STAGES-1];

`ifdef CMSDK_MCU_GPIO_IN_COND_DEBOUNCE_EN

  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (!db_en_i) begin
      stable_d = syn;
    end else if (syn != stable_q) begin
      // >= rather than == so a limit lowered mid-count cannot let the
      // counter run past it and wrap.
      if (cnt_q >= db_limit_i) begin
        stable_d = syn;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`else

  logic unused_db;
  assign unused_db = ^{db_en_i, db_limit_i};

  always_comb begin
    stable_d = syn;
  end

`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/cmsdk_mcu_gpio_in_cond.sv
// -----------------------------------------------------------------------------
// cmsdk_mcu_gpio_in_cond
// Input conditioning for one MCU GPIO port: per-bit synchroniser, optional
// debounce, conditioned data and sticky edge/level interrupt status.
//   HCLK      block clock
//   HRESET    synchronous active-high reset
//   pin_in    raw pad inputs from the pin mux (asynchronous)
//   db_en     per-bit debounce enable
//   db_limit  shared debounce limit
//   inten     per-bit interrupt enable
//   inttype   per-bit type: 1 = edge, 0 = level
//   intpol    per-bit polarity: 1 = rising/high, 0 = falling/low
//   intclr    per-bit one-cycle status clear
//   data_out  conditioned pin values
//   intstatus sticky interrupt status
//   combint   OR of intstatus (combinational)
// Build option: CMSDK_MCU_GPIO_IN_COND_DEBOUNCE_EN enables the debounce
// counters; when undefined db_en/db_limit are ignored.
// SYNC_STAGES must be 2 or 3.
// -----------------------------------------------------------------------------
module cmsdk_mcu_gpio_in_cond
  import cmsdk_mcu_gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CNT_W    = DB_CNT_W_DEF
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [WIDTH-1:0]    pin_in,
  input  logic [WIDTH-1:0]    db_en,
  input  logic [DB_CNT_W-1:0] db_limit,
  input  logic [WIDTH-1:0]    inten,
  input  logic [WIDTH-1:0]    inttype,
  input  logic [WIDTH-1:0]    intpol,
  input  logic [WIDTH-1:0]    intclr,
  output logic [WIDTH-1:0]    data_out,
  output logic [WIDTH-1:0]    intstatus,
  output logic                combint
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise, fall, int_set;
  logic [WIDTH-1:0] intstatus_q, intstatus_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cmsdk_mcu_gpio_in_cond_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT_W    (DB_CNT_W)
    ) u_bit (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .pin_i      (pin_in[i]),
      .db_en_i    (db_en[i]),
      .db_limit_i (db_limit),
      .stable_o   (stable[i])
    );
  end

  always_comb begin
    rise = stable & ~prev_q;
    fall = ~stable & prev_q;
    for (int i = 0; i < WIDTH; i++) begin
      int_set[i] = gpio_int_set(inten[i], inttype[i], intpol[i],
                                stable[i], rise[i], fall[i]);
    end
    // Set has priority over clear, so a persisting level re-asserts.
    intstatus_d = (intstatus_q & ~intclr) | int_set;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      prev_q      <= '0;
      intstatus_q <= '0;
    end else begin
      prev_q      <= stable;
      intstatus_q <= intstatus_d;
    end
  end

  assign data_out  = stable;
  assign intstatus = intstatus_q;
  assign combint   = |intstatus_q;

endmodule

// File: tb/tb_cmsdk_mcu_gpio_in_cond.sv
module tb_cmsdk_mcu_gpio_in_cond;

  localparam int W  = 16;
  localparam int SS = 2;
  localparam int CW = 4;

`ifdef CMSDK_MCU_GPIO_IN_COND_DEBOUNCE_EN
  localparam bit DB_BUILD = 1'b1;
`else
  localparam bit DB_BUILD = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [W-1:0]  pin_in, db_en, inten, inttype, intpol, intclr;
  logic [CW-1:0] db_limit;
  logic [W-1:0]  data_out, intstatus;
  logic          combint;

  int total = 0;
  int bad   = 0;

  cmsdk_mcu_gpio_in_cond #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CNT_W(CW)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .pin_in    (pin_in),
    .db_en     (db_en),
    .db_limit  (db_limit),
    .inten     (inten),
    .inttype   (inttype),
    .intpol    (intpol),
    .intclr    (intclr),
    .data_out  (data_out),
    .intstatus (intstatus),
    .combint   (combint)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: syn is the pin as sampled SS edges ago; a debounced bit
  // adopts syn once it has disagreed with the conditioned value for at least
  // db_limit+1 consecutive edges.
  logic [W-1:0] pin_hist[$];
  int           run[W];
  logic [W-1:0] m_stable, m_prev, m_status;

  task automatic model_reset();
    pin_hist.delete();
    repeat (SS) pin_hist.push_front('0);
    foreach (run[b]) run[b] = 0;
    m_stable = '0;
    m_prev   = '0;
    m_status = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] syn, nxt, rise, fall, set;
    if (HRESET) begin
      model_reset();
      return;
    end
    syn = pin_hist[SS-1];
    nxt = m_stable;
    for (int b = 0; b < W; b++) begin
      if (!DB_BUILD || !db_en[b]) begin
        nxt[b] = syn[b];
        run[b] = 0;
      end else if (syn[b] == m_stable[b]) begin
        run[b] = 0;
      end else begin
        run[b]++;
        if (run[b] >= int'(db_limit) + 1) begin
          nxt[b] = syn[b];
          run[b] = 0;
        end
      end
    end
    rise = m_stable & ~m_prev;
    fall = ~m_stable & m_prev;
    for (int b = 0; b < W; b++) begin
      if (!inten[b])        set[b] = 1'b0;
      else if (inttype[b])  set[b] = intpol[b] ? rise[b] : fall[b];
      else                  set[b] = (m_stable[b] == intpol[b]);
    end
    m_status = (m_status & ~intclr) | set;
    m_prev   = m_stable;
    m_stable = nxt;
    pin_hist.push_front(pin_in);
    void'(pin_hist.pop_back());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      model_edge();
      @(negedge HCLK);
      check("data_out", data_out, m_stable);
      check("intstatus", intstatus, m_status);
      check("combint", combint, |m_status);
    end
  endtask

  logic seen;
  int   lat;

  initial begin
    HRESET   = 1'b1;
    pin_in   = '0;
    db_en    = '0;
    db_limit = '0;
    inten    = '0;
    inttype  = '0;
    intpol   = '0;
    intclr   = '0;
    model_reset();
    step(3);
    check("rst_data", data_out, 0);
    check("rst_status", intstatus, 0);
    check("rst_combint", combint, 0);
    HRESET = 1'b0;
    step(2);

    // Bypass latency on bit 3
    pin_in[3] = 1'b1;
    step(2);
    check("t1_early", data_out[3], 0);
    step(1);
    check("t1_lat3", data_out[3], 1);
    check("t1_nostat", intstatus, 0);

    // Debounce reject then accept on bit 0
    db_en[0] = 1'b1;
    db_limit = 4'd4;
    pin_in[0] = 1'b1;
    step(3);
    pin_in[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step(1);
      seen |= data_out[0];
    end
    check("t2_glitch", seen, DB_BUILD ? 0 : 1);
    lat = DB_BUILD ? 7 : 3;
    pin_in[0] = 1'b1;
    step(lat - 1);
    check("t2_before", data_out[0], 0);
    step(1);
    check("t2_accept", data_out[0], 1);
    step(4);
    pin_in[0] = 1'b0;
    step(10);

    // Falling-edge interrupt on bit 5
    pin_in[5] = 1'b1;
    step(5);
    inten[5] = 1'b1; inttype[5] = 1'b1; intpol[5] = 1'b0;
    step(2);
    pin_in[5] = 1'b0;
    step(3);
    check("t3_notyet", intstatus[5], 0);
    step(1);
    check("t3_set", intstatus[5], 1);
    check("t3_comb", combint, 1);
    step(5);
    check("t3_sticky", intstatus[5], 1);
    intclr[5] = 1'b1;
    step(1);
    intclr[5] = 1'b0;
    check("t3_clr", intstatus[5], 0);
    check("t3_comb0", combint, 0);

    // High-level interrupt on bit 2, set beats clear
    inten[2] = 1'b1; inttype[2] = 1'b0; intpol[2] = 1'b1;
    pin_in[2] = 1'b1;
    step(4);
    check("t4_set", intstatus[2], 1);
    intclr[2] = 1'b1;
    step(1);
    intclr[2] = 1'b0;
    check("t4_setwins", intstatus[2], 1);
    pin_in[2] = 1'b0;
    step(5);
    check("t4_sticky", intstatus[2], 1);
    intclr[2] = 1'b1;
    step(1);
    intclr[2] = 1'b0;
    check("t4_clr", intstatus[2], 0);
    step(2);

    // Reset in the middle of a long debounce on bit 7
    db_limit = 4'd15;
    db_en[7] = 1'b1;
    pin_in[7] = 1'b1;
    step(8);
    HRESET = 1'b1;
    step(1);
    HRESET = 1'b0;
    check("t5_data0", data_out, 0);
    check("t5_stat0", intstatus, 0);
    lat = DB_BUILD ? 18 : 3;
    step(lat - 1);
    check("t5_before", data_out[7], 0);
    step(1);
    check("t5_after", data_out[7], 1);

`ifndef CMSDK_MCU_GPIO_IN_COND_DEBOUNCE_EN
    // Debounce compiled out: controls are ignored, latency stays 3
    pin_in = '0;
    db_en = '1;
    db_limit = 4'd15;
    step(4);
    pin_in = 16'h5AC3;
    step(2);
    check("t6_early", data_out, 0);
    step(1);
    check("t6_lat3", data_out, 16'h5AC3);
`endif

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        db_en    = W'($urandom);
        db_limit = CW'($urandom_range(0, 15));
        inten    = W'($urandom);
        inttype  = W'($urandom);
        intpol   = W'($urandom);
      end
      pin_in = pin_in ^ W'($urandom & $urandom & $urandom);
      intclr = W'($urandom & $urandom);
      HRESET = ($urandom_range(0, 499) == 0);
      step(1);
    end
    HRESET = 1'b0;
    intclr = '0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
